// File: rtl/mcpu_core_pkg.sv
// Shared types and widths for the mcpu core front end.
package mcpu_core_pkg;

  localparam int unsigned PACKET_W = 128;
  localparam int unsigned PC_W     = 28;

  // One buffered fetch packet together with its 16-byte-aligned address [31:4].
  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [PACKET_W-1:0] packet;
  } fetch_entry_t;

endpackage

// File: rtl/mcpu_core_fetch_if.sv
// Fetch unit bus bundle: il1c request/response, redirect input, decode handoff.
interface mcpu_core_fetch_if;
  import mcpu_core_pkg::*;

  logic [PC_W-1:0]     il1c_addr;
  logic                il1c_re;
  logic [PACKET_W-1:0] il1c_packet;
  logic                il1c_ready;
  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_addr;
  logic                fetch2dec_valid;
  logic [PACKET_W-1:0] fetch2dec_packet;
  logic [PC_W-1:0]     fetch2dec_pc;
  logic                dec2fetch_ready;

  // Fetch unit side.
  modport master (
    output il1c_addr, il1c_re, fetch2dec_valid, fetch2dec_packet, fetch2dec_pc,
    input  il1c_packet, il1c_ready, redirect_valid, redirect_addr, dec2fetch_ready
  );

  // Environment side (il1c, branch unit, decode).
  modport slave (
    input  il1c_addr, il1c_re, fetch2dec_valid, fetch2dec_packet, fetch2dec_pc,
    output il1c_packet, il1c_ready, redirect_valid, redirect_addr, dec2fetch_ready
  );

endinterface

// File: rtl/mcpu_core_fetch_fifo.sv
// Synchronous FIFO with occupancy count and flush; no push-to-pop bypass.
module mcpu_core_fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Status, effective push/pop and pointer/count next state; flush wins.
  always_comb begin
    full_o   = (count_q == CntW'(Depth));
    empty_o  = (count_q == '0);
    count_o  = count_q;
    rdata_o  = mem_q[rd_ptr_q];
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mcpu_core_fetch.sv
// Instruction fetch front end: sequential packet requests to il1c, redirect
// handling with stale-response squashing, and a packet FIFO feeding decode.
module mcpu_core_fetch
  import mcpu_core_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic               clkrst_mem_clk,
  input logic               clkrst_mem_rst,
  mcpu_core_fetch_if.master fetch_bus
);
  localparam int unsigned     CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PC_W-1:0] ResetPkt = RESET_PC[31:4];

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] hold_addr_q, hold_addr_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            hold_q, hold_d;
  logic            req_stale_q, req_stale_d;
  logic            inflight_q, inflight_d;
  logic            inflight_stale_q, inflight_stale_d;

  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic [CntW:0]   occupancy;
  logic            issue_ok, accept, push, pop, redirect;
  fetch_entry_t    push_entry, head_entry;

  // Request/decode outputs and next state of pc, hold and inflight tracking.
  always_comb begin
    redirect  = fetch_bus.redirect_valid;
    occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    issue_ok  = (occupancy < (CntW + 1)'(FIFO_DEPTH));
    // A stalled request keeps its slot; a held stale request keeps its old address.
    fetch_bus.il1c_re   = ~clkrst_mem_rst & (hold_q | issue_ok);
    fetch_bus.il1c_addr = hold_q ? hold_addr_q : pc_q;
    accept = fetch_bus.il1c_re & fetch_bus.il1c_ready;

    push       = fetch_bus.il1c_ready & inflight_q & ~inflight_stale_q & ~redirect;
    push_entry = '{pc: inflight_pc_q, packet: fetch_bus.il1c_packet};

    fetch_bus.fetch2dec_valid  = ~clkrst_mem_rst & ~fifo_empty;
    fetch_bus.fetch2dec_packet = head_entry.packet;
    fetch_bus.fetch2dec_pc     = head_entry.pc;
    pop = fetch_bus.fetch2dec_valid & fetch_bus.dec2fetch_ready & ~redirect;

    // pc already points at the new target when a stale held request is accepted.
    pc_d = pc_q;
    if (accept && !req_stale_q) pc_d = pc_q + PC_W'(1);
    if (redirect) pc_d = fetch_bus.redirect_addr;

    hold_d      = fetch_bus.il1c_re & ~fetch_bus.il1c_ready;
    hold_addr_d = fetch_bus.il1c_addr;
    req_stale_d = hold_d & (req_stale_q | redirect);

    inflight_pc_d = accept ? fetch_bus.il1c_addr : inflight_pc_q;
    if (fetch_bus.il1c_ready) begin
      inflight_d       = accept;
      inflight_stale_d = accept & (req_stale_q | redirect);
    end else begin
      inflight_d       = inflight_q;
      inflight_stale_d = inflight_stale_q | redirect;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      pc_q             <= ResetPkt;
      hold_q           <= 1'b0;
      hold_addr_q      <= '0;
      req_stale_q      <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_stale_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      hold_q           <= hold_d;
      hold_addr_q      <= hold_addr_d;
      req_stale_q      <= req_stale_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_stale_q <= inflight_stale_d;
    end
  end

  mcpu_core_fetch_fifo #(
    .Depth(FIFO_DEPTH),
    .Width($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i  (clkrst_mem_clk),
    .rst_i  (clkrst_mem_rst),
    .flush_i(redirect),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .rdata_o(head_entry),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // The issue rule reserves a slot per inflight request, so a push never meets a full FIFO.
  assert property (@(posedge clkrst_mem_clk) disable iff (clkrst_mem_rst)
                   !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mcpu_core_fetch.sv
// Self-checking bench for mcpu_core_fetch with an il1c model and a stream scoreboard.
module tb_mcpu_core_fetch;
  import mcpu_core_pkg::*;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcpu_core_fetch_if bus ();

  mcpu_core_fetch #(
    .FIFO_DEPTH(Depth),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clkrst_mem_clk(clk),
    .clkrst_mem_rst(rst),
    .fetch_bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  logic [27:0] exp_next = '0;
  logic [27:0] last_deliv_pc = '0;
  logic        pend = 1'b0;
  logic [27:0] pend_addr = '0;
  logic        prev_stall = 1'b0;
  logic [27:0] prev_addr = '0;
  logic        obs_re, obs_valid;

  // Reference contents of the instruction memory at a packet address.
  function automatic logic [127:0] pkt_of(input logic [27:0] pc);
    return {4'h1, pc, 4'h2, ~pc, 4'h3, pc ^ 28'h5A5A5A5, 4'h4, {pc[13:0], pc[27:14]}};
  endfunction

  // One clock cycle: drive inputs, score the stream at negedge, advance to posedge+1.
  task automatic tick(input logic rdy, input logic dec_rdy, input logic rv,
                      input logic [27:0] ra);
    bus.il1c_ready      = rdy;
    bus.dec2fetch_ready = dec_rdy;
    bus.redirect_valid  = rv;
    bus.redirect_addr   = ra;
    bus.il1c_packet     = (pend && rdy) ? pkt_of(pend_addr)
                                        : {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    obs_re    = bus.il1c_re;
    obs_valid = bus.fetch2dec_valid;
    if (rst) begin
      exp_next   = '0;
      pend       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (bus.il1c_re !== 1'b1 || bus.il1c_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL hold_stable: re=%b addr=%h, required re=1 addr=%h",
                   bus.il1c_re, bus.il1c_addr, prev_addr);
        end
      end
      if (rv) begin
        exp_next = ra;
      end else if (bus.fetch2dec_valid === 1'b1 && dec_rdy) begin
        n_checks++;
        if (bus.fetch2dec_pc !== exp_next || bus.fetch2dec_packet !== pkt_of(exp_next)) begin
          n_fail++;
          $display("FAIL deliver: pc=%h packet=%h, required pc=%h packet=%h",
                   bus.fetch2dec_pc, bus.fetch2dec_packet, exp_next, pkt_of(exp_next));
        end
        n_deliv++;
        last_deliv_pc = bus.fetch2dec_pc;
        exp_next = bus.fetch2dec_pc + 28'd1;
      end
      if (bus.il1c_re === 1'b1 && rdy) begin
        pend      = 1'b1;
        pend_addr = bus.il1c_addr;
      end else if (rdy) begin
        pend = 1'b0;
      end
      prev_stall = (bus.il1c_re === 1'b1) && !rdy;
      prev_addr  = bus.il1c_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b0, '0);
    n_checks++;
    if (obs_re !== 1'b0 || obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle: re=%b valid=%b, required 0 0", obs_re, obs_valid);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.il1c_re !== 1'b1 || bus.il1c_addr !== 28'h0 || bus.fetch2dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: re=%b addr=%h valid=%b, required 1 0000000 0",
               bus.il1c_re, bus.il1c_addr, bus.fetch2dec_valid);
    end
  endtask

  task automatic test_stream();
    int n1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, '0);
    n1 = n_deliv;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, '0);
    n_checks++;
    if (n_deliv - n1 != 10 || last_deliv_pc !== 28'hA) begin
      n_fail++;
      $display("FAIL stream_rate: delivered=%0d last=%h, required 10 000000a",
               n_deliv - n1, last_deliv_pc);
    end
  endtask

  task automatic test_il1c_stall();
    int guard = 0;
    while (!(bus.il1c_re === 1'b1 && bus.il1c_addr === 28'h10) && guard < 40) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (bus.il1c_re !== 1'b1 || bus.il1c_addr !== 28'h10) begin
        n_fail++;
        $display("FAIL stall_hold: re=%b addr=%h, required 1 0000010",
                 bus.il1c_re, bus.il1c_addr);
      end
    end
    guard = 0;
    while (exp_next !== 28'h12 && guard < 10) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    n_checks++;
    if (exp_next !== 28'h12 || last_deliv_pc !== 28'h11) begin
      n_fail++;
      $display("FAIL stall_resume: next=%h last=%h, required 0000012 0000011",
               exp_next, last_deliv_pc);
    end
  endtask

  task automatic test_decode_stall();
    int n0;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.il1c_re !== 1'b0 || bus.fetch2dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_stall_full: re=%b valid=%b, required 0 1",
               bus.il1c_re, bus.fetch2dec_valid);
    end
    n0 = n_deliv;
    for (int i = 0; i < 10 && bus.fetch2dec_valid === 1'b1; i++) tick(1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (n_deliv - n0 != int'(Depth)) begin
      n_fail++;
      $display("FAIL dec_stall_count: buffered=%0d, required %0d", n_deliv - n0, Depth);
    end
    n0 = n_deliv;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, '0);
    n_checks++;
    if (n_deliv - n0 < 4) begin
      n_fail++;
      $display("FAIL dec_stall_resume: delivered=%0d, required >= 4", n_deliv - n0);
    end
  endtask

  task automatic test_redirect_inflight();
    int guard = 0;
    tick(1'b1, 1'b0, 1'b1, 28'h10);
    while (!(pend && pend_addr === 28'h12) && guard < 6) begin
      tick(1'b1, 1'b0, 1'b0, '0);
      guard++;
    end
    n_checks++;
    if (!(pend && pend_addr === 28'h12) || bus.fetch2dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_setup: pend=%b addr=%h valid=%b, required 1 0000012 1",
               pend, pend_addr, bus.fetch2dec_valid);
    end
    tick(1'b1, 1'b1, 1'b1, 28'h400);
    n_checks++;
    if (bus.fetch2dec_valid !== 1'b0 || bus.il1c_re !== 1'b1 || bus.il1c_addr !== 28'h400) begin
      n_fail++;
      $display("FAIL redir_flush: valid=%b re=%b addr=%h, required 0 1 0000400",
               bus.fetch2dec_valid, bus.il1c_re, bus.il1c_addr);
    end
    tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b0, '0);
    n_checks++;
    if (bus.fetch2dec_valid !== 1'b1 || bus.fetch2dec_pc !== 28'h400) begin
      n_fail++;
      $display("FAIL redir_latency: valid=%b pc=%h, required 1 0000400",
               bus.fetch2dec_valid, bus.fetch2dec_pc);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic test_redirect_stall();
    int n0;
    int guard = 0;
    tick(1'b1, 1'b1, 1'b1, 28'h30);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 28'h200);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (bus.il1c_re !== 1'b1 || bus.il1c_addr !== 28'h30) begin
        n_fail++;
        $display("FAIL redir_stall_hold: re=%b addr=%h, required 1 0000030",
                 bus.il1c_re, bus.il1c_addr);
      end
    end
    tick(1'b1, 1'b1, 1'b0, '0);
    n_checks++;
    if (bus.il1c_re !== 1'b1 || bus.il1c_addr !== 28'h200) begin
      n_fail++;
      $display("FAIL redir_stall_next: re=%b addr=%h, required 1 0000200",
               bus.il1c_re, bus.il1c_addr);
    end
    n0 = n_deliv;
    while (n_deliv == n0 && guard < 10) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    n_checks++;
    if (n_deliv == n0 || last_deliv_pc !== 28'h200) begin
      n_fail++;
      $display("FAIL redir_stall_first: delivered=%0d pc=%h, required 1 0000200",
               n_deliv - n0, last_deliv_pc);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    int guard = 0;
    tick(1'b1, 1'b1, 1'b1, 28'h500);
    tick(1'b1, 1'b1, 1'b1, 28'h600);
    n0 = n_deliv;
    while (n_deliv == n0 && guard < 10) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    n_checks++;
    if (n_deliv == n0 || last_deliv_pc !== 28'h600) begin
      n_fail++;
      $display("FAIL back_to_back: pc=%h, required 0000600", last_deliv_pc);
    end
  endtask

  task automatic test_wrap_and_reset();
    int n0;
    int guard = 0;
    logic [27:0] seen [2];
    seen[0] = '1;
    seen[1] = '1;
    tick(1'b1, 1'b1, 1'b1, 28'hFFFFFFF);
    n0 = n_deliv;
    while (n_deliv < n0 + 2 && guard < 12) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      if (n_deliv > n0 && n_deliv <= n0 + 2) seen[n_deliv - n0 - 1] = last_deliv_pc;
      guard++;
    end
    n_checks++;
    if (seen[0] !== 28'hFFFFFFF || seen[1] !== 28'h0) begin
      n_fail++;
      $display("FAIL wrap: pcs=%h,%h, required fffffff,0000000", seen[0], seen[1]);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, '0);
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0, '0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_re !== 1'b0 || bus.fetch2dec_valid !== 1'b0 || bus.il1c_addr !== 28'h0 ||
        bus.il1c_re !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: re_in_rst=%b valid=%b addr=%h re=%b, required 0 0 0000000 1",
               obs_re, bus.fetch2dec_valid, bus.il1c_addr, bus.il1c_re);
    end
    n0 = n_deliv;
    guard = 0;
    while (n_deliv == n0 && guard < 10) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    n_checks++;
    if (n_deliv == n0 || last_deliv_pc !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_restart: pc=%h, required 0000000", last_deliv_pc);
    end
  endtask

  task automatic test_random();
    int n0 = n_deliv;
    for (int i = 0; i < 400; i++) begin
      logic        rdy, drdy, rv;
      logic [27:0] ra;
      rdy  = ($urandom_range(0, 3) != 0);
      drdy = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 24) == 0);
      ra   = ($urandom_range(0, 3) == 0) ? 28'hFFFFFFE : 28'($urandom);
      if (!rv && $urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        tick(rdy, drdy, 1'b0, '0);
        rst = 1'b0;
      end else begin
        tick(rdy, drdy, rv, ra);
      end
    end
    n_checks++;
    if (n_deliv - n0 <= 40) begin
      n_fail++;
      $display("FAIL random_progress: delivered=%0d, required > 40", n_deliv - n0);
    end
  endtask

  initial begin
    bus.il1c_ready      = 1'b0;
    bus.dec2fetch_ready = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_addr   = '0;
    bus.il1c_packet     = '0;
    test_reset();
    test_stream();
    test_il1c_stall();
    test_decode_stall();
    test_redirect_inflight();
    test_redirect_stall();
    test_back_to_back();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
